// File: rtl/chunk_serial_adder.sv
// chunk_serial_adder: multi-cycle add/subtract, CHUNK bits per clock, LSB chunk first,
// carry rippled between chunks through a register; start/busy/done handshake.
module chunk_serial_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = N > 1 ? $clog2(N) : 1;

    generate
        if (CHUNK < 1 || CHUNK > WIDTH || WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("chunk_serial_adder: CHUNK must divide WIDTH and lie in 1..WIDTH");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_r, b_r, work, work_nxt;
    logic             c_r, c_out, c_msb, last;
    logic [CHUNK-1:0] sa, sb, s;

    always_comb begin
        sa = a_r[cnt*CHUNK +: CHUNK];
        sb = b_r[cnt*CHUNK +: CHUNK];
        {c_out, s} = {1'b0, sa} + {1'b0, sb} + {{CHUNK{1'b0}}, c_r};
        // carry into the chunk MSB recovered from its sum bit
        c_msb = s[CHUNK-1] ^ sa[CHUNK-1] ^ sb[CHUNK-1];
        last = cnt == CW'(N - 1);
        work_nxt = work;
        work_nxt[cnt*CHUNK +: CHUNK] = s;
    end

    always_comb begin
        state_nxt = state;
        busy      = state == RUN;
        if (state == IDLE)
            state_nxt = start ? RUN : IDLE;
        else
            state_nxt = last ? IDLE : RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            a_r      <= '0;
            b_r      <= '0;
            c_r      <= 1'b0;
            work     <= '0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                a_r <= a;
                b_r <= sub ? ~b : b;
                c_r <= cin ^ sub;
                cnt <= '0;
            end else if (state == RUN) begin
                work <= work_nxt;
                c_r  <= c_out;
                cnt  <= cnt + 1'b1;
                if (last) begin
                    sum      <= work_nxt;
                    carry    <= c_out;
                    overflow <= c_msb ^ c_out;
                    done     <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_chunk_serial_adder.sv
// tb_chunk_serial_adder: four instances (8/2, 8/1, 8/8, 1/1) driven together and
// compared against an integer-arithmetic reference model.
module tb_chunk_serial_adder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] av, bv;
    logic       cin, sub;
    logic       start_v [4];
    logic       busy_v  [4];
    logic       done_v  [4];
    logic       carry_v [4];
    logic       ov_v    [4];
    logic [7:0] sum_v   [4];
    logic [0:0] s1;
    logic [9:0] prev    [4];
    int         n_chk = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;

    chunk_serial_adder #(.WIDTH(8), .CHUNK(2)) u_c2 (.clk(clk), .rst_n(rst_n), .start(start_v[0]),
        .a(av), .b(bv), .cin(cin), .sub(sub), .busy(busy_v[0]), .done(done_v[0]),
        .sum(sum_v[0]), .carry(carry_v[0]), .overflow(ov_v[0]));
    chunk_serial_adder #(.WIDTH(8), .CHUNK(1)) u_c1 (.clk(clk), .rst_n(rst_n), .start(start_v[1]),
        .a(av), .b(bv), .cin(cin), .sub(sub), .busy(busy_v[1]), .done(done_v[1]),
        .sum(sum_v[1]), .carry(carry_v[1]), .overflow(ov_v[1]));
    chunk_serial_adder #(.WIDTH(8), .CHUNK(8)) u_c8 (.clk(clk), .rst_n(rst_n), .start(start_v[2]),
        .a(av), .b(bv), .cin(cin), .sub(sub), .busy(busy_v[2]), .done(done_v[2]),
        .sum(sum_v[2]), .carry(carry_v[2]), .overflow(ov_v[2]));
    chunk_serial_adder #(.WIDTH(1), .CHUNK(1)) u_w1 (.clk(clk), .rst_n(rst_n), .start(start_v[3]),
        .a(av[0:0]), .b(bv[0:0]), .cin(cin), .sub(sub), .busy(busy_v[3]), .done(done_v[3]),
        .sum(s1), .carry(carry_v[3]), .overflow(ov_v[3]));
    assign sum_v[3] = {7'h0, s1};

    function automatic int nof(input int i);
        return i == 0 ? 4 : i == 1 ? 8 : 1;
    endfunction

    function automatic int wof(input int i);
        return i == 3 ? 1 : 8;
    endfunction

    // returns {overflow, carry, sum[7:0]} from plain unsigned and signed integer arithmetic
    function automatic logic [9:0] model(input int w, input logic [7:0] a, input logic [7:0] b,
                                          input logic ci, input logic su);
        int m, ua, ub, full, sa, sb, st;
        logic c, ov;
        m    = (1 << w) - 1;
        ua   = int'(a) & m;
        ub   = int'(b) & m;
        full = ua + (su ? (~ub & m) : ub) + int'(ci ^ su);
        sa   = ua >= (1 << (w - 1)) ? ua - (1 << w) : ua;
        sb   = ub >= (1 << (w - 1)) ? ub - (1 << w) : ub;
        st   = su ? sa - sb - int'(ci) : sa + sb + int'(ci);
        c    = ((full >> w) & 1) == 1;
        ov   = st > (1 << (w - 1)) - 1 || st < -(1 << (w - 1));
        return {ov, c, 8'(full & m)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic chk_res(input int i, input string tag, input logic [9:0] e);
        chk($sformatf("%s_sum%0d", tag, i), 32'(sum_v[i]), 32'(e[7:0]));
        chk($sformatf("%s_carry%0d", tag, i), 32'(carry_v[i]), 32'(e[8]));
        chk($sformatf("%s_ov%0d", tag, i), 32'(ov_v[i]), 32'(e[9]));
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input logic su, input bit disturb);
        logic [9:0] exp [4];
        for (int i = 0; i < 4; i++) exp[i] = model(wof(i), a, b, ci, su);
        @(negedge clk);
        av = a; bv = b; cin = ci; sub = su;
        for (int i = 0; i < 4; i++) start_v[i] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) start_v[i] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("busy%0d_k%0d", i, k), 32'(busy_v[i]), 32'(k < nof(i)));
                chk($sformatf("done%0d_k%0d", i, k), 32'(done_v[i]), 32'(k == nof(i)));
                chk_res(i, "op", k < nof(i) ? prev[i] : exp[i]);
            end
            if (disturb && k == 1) begin
                start_v[0] = 1'b1;
                av = 8'($urandom); bv = 8'($urandom);
                cin = 1'($urandom); sub = 1'($urandom);
            end
            if (disturb && k == 2) start_v[0] = 1'b0;
        end
        for (int i = 0; i < 4; i++) prev[i] = exp[i];
    endtask

    initial begin
        logic [9:0] q [$];
        logic [9:0] e;
        int last_done, n_done;
        for (int i = 0; i < 4; i++) begin
            start_v[i] = 1'b0;
            prev[i]    = '0;
        end
        av = '0; bv = '0; cin = 1'b0; sub = 1'b0;

        // reset with random inputs toggling
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            av = 8'($urandom); bv = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            for (int i = 0; i < 4; i++) start_v[i] = 1'($urandom);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("rst_busy%0d", i), 32'(busy_v[i]), 0);
                chk($sformatf("rst_done%0d", i), 32'(done_v[i]), 0);
                chk_res(i, "rst", '0);
            end
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) start_v[i] = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("idle_busy%0d", i), 32'(busy_v[i]), 0);
                chk($sformatf("idle_done%0d", i), 32'(done_v[i]), 0);
                chk_res(i, "idle", '0);
            end
        end

        // directed vectors
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        run_op(8'h05, 8'h07, 1'b0, 1'b1, 1'b0);
        run_op(8'h07, 8'h05, 1'b0, 1'b1, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 1'b0, 1'b1, 1'b0);

        // exhaustive one-bit full adder
        for (int v = 0; v < 8; v++) begin
            logic ab, bb, cb;
            {ab, bb, cb} = 3'(v);
            run_op({8{ab}}, {8{bb}}, cb, 1'b0, 1'b0);
            chk($sformatf("fa_sum_%0d", v), 32'(sum_v[3][0]), 32'(ab ^ bb ^ cb));
            chk($sformatf("fa_cy_%0d", v), 32'(carry_v[3]), 32'((ab & bb) | (ab & cb) | (bb & cb)));
        end

        // start and operand changes while busy are ignored
        for (int r = 0; r < 4; r++)
            run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1);

        // random operations
        for (int r = 0; r < 20; r++)
            run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);

        // start held high: back-to-back on the CHUNK=2 instance
        last_done = -1;
        n_done = 0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (c > 0 && done_v[0]) begin
                e = q.pop_front();
                chk_res(0, "b2b", e);
                prev[0] = e;
                if (last_done >= 0) chk("b2b_gap", 32'(c - last_done), 5);
                last_done = c;
                n_done++;
            end
            av = 8'($urandom); bv = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            start_v[0] = 1'b1;
            if (!busy_v[0]) q.push_back(model(8, av, bv, cin, sub));
        end
        start_v[0] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done_v[0]) begin
                e = q.pop_front();
                chk_res(0, "b2b_drain", e);
                prev[0] = e;
                n_done++;
            end
        end
        chk("b2b_count", 32'(n_done), 7);
        chk("b2b_queue", 32'(q.size()), 0);

        // reset in the middle of an operation
        @(negedge clk);
        av = 8'h12; bv = 8'h34; cin = 1'b0; sub = 1'b0;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy_v[0]), 0);
        chk("abort_done", 32'(done_v[0]), 0);
        chk_res(0, "abort", '0);
        for (int i = 0; i < 4; i++) prev[i] = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort_nodone", 32'(done_v[0]), 0);
            chk_res(0, "abort_hold", '0);
        end
        rst_n = 1'b1;
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/chunk_serial_adder.md
# chunk_serial_adder

Multi-cycle, parametrised add/subtract unit that processes a WIDTH-bit operand pair CHUNK bits per clock, LSB chunk first, rippling the carry between chunks through a register. It generalises the single-bit full adder to any word width and adds a subtract mode, a signed-overflow flag and a start/busy/done handshake. It sits beside the combinational arithmetic blocks and serves datapaths that trade latency for area.

## Interface
- WIDTH, 8: operand/result width in bits; ≥1.
- CHUNK, 2: bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH, WIDTH % CHUNK == 0 (elaboration error otherwise). N = WIDTH/CHUNK.

- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request a new operation; sampled only when not busy.
- a  input  WIDTH  operand A, captured at the accepting edge.
- b  input  WIDTH  operand B, captured at the accepting edge.
- cin  input  1  carry-in, captured at the accepting edge.
- sub  input  1  0 = A+B+cin; 1 = A+~B+~cin (A−B−cin), captured at the accepting edge.
- busy  output  1  operation in progress.
- done  output  1  single-cycle pulse: results just updated.
- sum  output  WIDTH  result, held until the next completion.
- carry  output  1  carry-out of the MSB (for sub: 1 = no borrow).
- overflow  output  1  two's-complement overflow of the result.

## Operation
- States: IDLE, RUN. done is a registered flag, not a state.
- IDLE: start=1 at an edge → capture a, b (inverted if sub), effective carry = cin ^ sub; clear chunk counter; go RUN; busy=1.
- RUN: each edge adds the current CHUNK-bit slice of A and B plus the registered carry, writes the slice into an internal work register, stores the chunk carry-out, advances the counter.
- After the N-th RUN edge: copy work register to sum, final carry to carry, overflow = (carry into MSB) ^ (carry out of MSB); done=1 for one cycle; busy=0; go IDLE.
- sum/carry/overflow do not change during RUN; they change only at a completing edge or reset.
- start while busy: ignored, not queued.
- start in the cycle done=1: accepted (state is IDLE), giving back-to-back operations.
- CHUNK = WIDTH (N=1): one RUN edge; fully supported.
- Operands are ignored except at the accepting edge; changing a/b/cin/sub during RUN has no effect.
- Arithmetic is modulo 2^WIDTH; no saturation.

## Timing
- Reset (rst_n=0, asynchronous): state IDLE, busy=0, done=0, sum=0, carry=0, overflow=0, counter and work registers 0.
- Reset during RUN aborts: no done pulse, results forced to 0.
- Accepting edge T: busy=1 from T.
- Chunk i (0…N−1) computed at edge T+1+i.
- At edge T+N: results valid, done=1, busy=0; done falls at T+N+1 unless that edge completes another operation (impossible, since completion needs ≥ N+1 edges from acceptance).
- Throughput: one operation per N+1 cycles with start held high.
- Release of rst_n takes effect at the next clk edge; no start is accepted on the release edge itself if it violates setup (bench drives start=0 there).

## Test plan
(WIDTH=8, CHUNK=2, N=4 unless stated)
- Reset: hold rst_n=0 with random inputs → busy=0, done=0, sum=0x00, carry=0, overflow=0; release, start=0 for 5 cycles → outputs unchanged.
- Add with carry-out: a=0xFF, b=0x01, cin=0, sub=0, start one cycle at edge T → busy 1 on T…T+3, done=1 only after T+4, sum=0x00, carry=1, overflow=0; sum holds until next completion.
- Subtract with borrow: a=0x05, b=0x07, cin=0, sub=1 → sum=0xFE, carry=0, overflow=0; a=0x07, b=0x05 → sum=0x02, carry=1.
- Signed overflow: a=0x7F, b=0x01, sub=0 → sum=0x80, overflow=1, carry=0; a=0x80, b=0x01, sub=1 → sum=0x7F, overflow=1, carry=1.
- Handshake: pulse start again and change a/b during busy → ignored, result matches first operands; hold start high continuously → done every 5 cycles, each result matching the operands present at its accepting edge.
- Reset mid-operation plus parameter sweep: drop rst_n at T+2 → busy=0 immediately, no done, sum=0; rerun the add/sub/overflow vectors with CHUNK=1 (done after 8 edges), CHUNK=8 (done after 1 edge) and WIDTH=1 exhaustively over all 8 a/b/cin combinations against the full-adder truth table.
